// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: synchronizes/debounces buttons, sequences IDLE/RUN/PAUSE/DONE, drives timer strobes and blink.
// Latency: raw edge -> press pulse after sync + DEBOUNCE_CYCLES + 1; press -> state/pulse outputs one cycle later.
// Backpressure: none; inputs are levels/pulses sampled every cycle and all outputs are registered.
module stopwatch_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_TICKS     = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_raw,
    input  logic       btn_clear_raw,
    input  logic [1:0] mode_sw,
    input  logic [7:0] load_sw,
    input  logic       tick,
    input  logic       timer_zero,
    output logic       run_en,
    output logic       clear,
    output logic       load_strobe,
    output logic [7:0] load_value,
    output logic [1:0] mode_out,
    output logic       blank,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BCW = $clog2(BLINK_TICKS + 1);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BCW-1:0] BL_LAST = BCW'(BLINK_TICKS - 1);

    state_t cur_st, nxt_st;
    logic   clr_nxt, ld_nxt;

    logic [1:0]     raw;
    logic [1:0]     sync1, sync2, db, db_prev, press, armed;
    logic [DCW-1:0] db_cnt [2];
    logic [1:0]     settle;
    logic [BCW-1:0] blink_cnt;
    logic [1:0]     mode_sane;
    logic           start_press, clear_press;

    assign raw         = {btn_clear_raw, btn_start_raw};
    assign start_press = press[0];
    assign clear_press = press[1];
    assign mode_sane   = (mode_sw == 2'b01) ? 2'b01 : 2'b00;
    assign state       = cur_st;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    // A button must be seen released after reset before it may produce a press,
    // so a button held through reset does not fire on release of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            press   <= '0;
            armed   <= '0;
            settle  <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db;
            press   <= db & ~db_prev & armed;
            if (settle != 2'd2) settle <= settle + 2'd1;
            for (int i = 0; i < 2; i++) begin
                if (settle == 2'd2 && !sync2[i]) armed[i] <= 1'b1;
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= ~db[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DCW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        nxt_st  = cur_st;
        clr_nxt = 1'b0;
        ld_nxt  = 1'b0;
        if (clear_press) begin
            nxt_st  = IDLE;
            clr_nxt = 1'b1;
        end else begin
            case (cur_st)
                IDLE: if (start_press) begin
                    if (mode_out == 2'b01) begin
                        if (load_value != 8'h00) begin
                            nxt_st = RUN;
                            ld_nxt = 1'b1;
                        end
                    end else begin
                        nxt_st  = RUN;
                        clr_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (mode_out == 2'b01 && timer_zero) nxt_st = DONE;
                    else if (start_press)                nxt_st = PAUSE;
                end
                PAUSE:   if (start_press) nxt_st = RUN;
                DONE:    if (start_press) nxt_st = IDLE;
                default: nxt_st = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_st      <= IDLE;
            run_en      <= 1'b0;
            clear       <= 1'b0;
            load_strobe <= 1'b0;
            load_value  <= 8'h00;
            mode_out    <= 2'b00;
            blank       <= 1'b0;
            blink_cnt   <= '0;
        end else begin
            cur_st      <= nxt_st;
            run_en      <= (nxt_st == RUN);
            clear       <= clr_nxt;
            load_strobe <= ld_nxt;
            load_value  <= {bcd_clamp(load_sw[7:4]), bcd_clamp(load_sw[3:0])};
            if (cur_st == IDLE) mode_out <= mode_sane;
            // Blink restarts from 0 on every DONE entry and is forced off outside DONE.
            if (cur_st != DONE || nxt_st != DONE) begin
                blink_cnt <= '0;
                blank     <= 1'b0;
            end else if (tick) begin
                if (blink_cnt == BL_LAST) begin
                    blink_cnt <= '0;
                    blank     <= ~blank;
                end else begin
                    blink_cnt <= blink_cnt + BCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller: a behavioural model queues the expected outputs
// every cycle and an independent monitor compares them against the DUT on the falling edge.
module tb_stopwatch_controller;

    localparam int DB = 4;
    localparam int BT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start_raw, btn_clear_raw;
    logic [1:0] mode_sw;
    logic [7:0] load_sw;
    logic       tick, timer_zero;
    logic       run_en, clear, load_strobe, blank;
    logic [7:0] load_value;
    logic [1:0] mode_out, state;

    always #5 clk = ~clk;

    stopwatch_controller #(.DEBOUNCE_CYCLES(DB), .BLINK_TICKS(BT)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_start_raw(btn_start_raw),
        .btn_clear_raw(btn_clear_raw),
        .mode_sw      (mode_sw),
        .load_sw      (load_sw),
        .tick         (tick),
        .timer_zero   (timer_zero),
        .run_en       (run_en),
        .clear        (clear),
        .load_strobe  (load_strobe),
        .load_value   (load_value),
        .mode_out     (mode_out),
        .blank        (blank),
        .state        (state)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       run;
        logic       clr;
        logic       ld;
        logic [7:0] lv;
        logic [1:0] mode;
        logic       blank;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [3:0] clampn(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    // Reference model: state names as integers 0..3, buttons described by how long
    // the synchronized level has disagreed with the accepted level.
    int         m_state, m_ticks, since_rst;
    logic [1:0] m_mode;
    logic [7:0] m_lv;
    logic       m_run, m_clr, m_ld, m_blank;
    logic [1:0] pipe0, pipe1, level, rose, armed, pend;
    int         run_len [2];

    always @(posedge clk) begin : model
        int         nxt;
        logic       clr_n, ld_n, seen;
        logic [1:0] rawv, new_pend;
        obs_t       o;
        rawv = {btn_clear_raw, btn_start_raw};
        if (reset) begin
            m_state = 0; m_ticks = 0; since_rst = 0;
            m_mode = 2'b00; m_lv = 8'h00;
            m_run = 1'b0; m_clr = 1'b0; m_ld = 1'b0; m_blank = 1'b0;
            pipe0 = '0; pipe1 = '0; level = '0; rose = '0; armed = '0; pend = '0;
            run_len[0] = 0; run_len[1] = 0;
        end else begin
            nxt = m_state; clr_n = 1'b0; ld_n = 1'b0;
            if (pend[1]) begin
                nxt = 0; clr_n = 1'b1;
            end else if (m_state == 1 && m_mode == 2'b01 && timer_zero) begin
                nxt = 3;
            end else if (pend[0]) begin
                case (m_state)
                    0: if (m_mode == 2'b00) begin
                           nxt = 1; clr_n = 1'b1;
                       end else if (m_lv != 8'h00) begin
                           nxt = 1; ld_n = 1'b1;
                       end
                    1: nxt = 2;
                    2: nxt = 1;
                    3: nxt = 0;
                    default: ;
                endcase
            end
            if (m_state == 3 && nxt == 3) begin
                if (tick) m_ticks = m_ticks + 1;
            end else begin
                m_ticks = 0;
            end
            m_blank = ((m_ticks / BT) % 2) == 1;
            if (m_state == 0) m_mode = (mode_sw == 2'b01) ? 2'b01 : 2'b00;
            m_lv    = {clampn(load_sw[7:4]), clampn(load_sw[3:0])};
            m_run   = (nxt == 1);
            m_clr   = clr_n;
            m_ld    = ld_n;
            m_state = nxt;

            since_rst = since_rst + 1;
            for (int b = 0; b < 2; b++) begin
                seen        = pipe1[b];
                new_pend[b] = rose[b] & armed[b];
                rose[b]     = 1'b0;
                if (since_rst >= 3 && !seen) armed[b] = 1'b1;
                if (seen != level[b]) begin
                    run_len[b] = run_len[b] + 1;
                    if (run_len[b] == DB) begin
                        level[b]   = ~level[b];
                        run_len[b] = 0;
                        rose[b]    = level[b];
                    end
                end else begin
                    run_len[b] = 0;
                end
            end
            pipe1 = pipe0;
            pipe0 = rawv;
            pend  = new_pend;
        end
        o.st = 2'(m_state); o.run = m_run; o.clr = m_clr; o.ld = m_ld;
        o.lv = m_lv; o.mode = m_mode; o.blank = m_blank;
        exp_q.push_back(o);
    end

    always @(negedge clk) begin : monitor
        obs_t got, want;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {state, run_en, clear, load_strobe, load_value, mode_out, blank};
            checks = checks + 1;
            if (got !== want) begin
                fails = fails + 1;
                $display("FAIL outputs t=%0t got st=%0d run=%b clr=%b ld=%b lv=%h mode=%b blank=%b required st=%0d run=%b clr=%b ld=%b lv=%h mode=%b blank=%b",
                         $time, got.st, got.run, got.clr, got.ld, got.lv, got.mode, got.blank,
                         want.st, want.run, want.clr, want.ld, want.lv, want.mode, want.blank);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks = checks + 1;
        if (state !== 2'd0 || run_en !== 1'b0 || clear !== 1'b0 || load_strobe !== 1'b0 ||
            load_value !== 8'h00 || mode_out !== 2'b00 || blank !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL reset state (%s) t=%0t st=%0d run=%b clr=%b ld=%b lv=%h mode=%b blank=%b",
                     tag, $time, state, run_en, clear, load_strobe, load_value, mode_out, blank);
        end
    endtask

    task automatic wait_state(input logic [1:0] target, input int max_cycles, input string tag);
        int n;
        n = 0;
        while (state !== target && n < max_cycles) begin
            step(1);
            n = n + 1;
        end
        checks = checks + 1;
        if (state !== target) begin
            fails = fails + 1;
            $display("FAIL wait expired (%s) t=%0t state=%0d required %0d within %0d cycles",
                     tag, $time, state, target, max_cycles);
        end
    endtask

    task automatic press(input int which, input int hold, input int gap);
        if (which == 0) btn_start_raw = 1'b1; else btn_clear_raw = 1'b1;
        step(hold);
        if (which == 0) btn_start_raw = 1'b0; else btn_clear_raw = 1'b0;
        step(gap);
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step(1);
            tick = 1'b0; step(2);
        end
    endtask

    initial begin : stim
        int hold_s, hold_c;
        reset = 1'b1; btn_start_raw = 1'b0; btn_clear_raw = 1'b0;
        mode_sw = 2'b00; load_sw = 8'h00; tick = 1'b0; timer_zero = 1'b0;
        step(3);
        check_reset_outputs("power-on");
        reset = 1'b0;
        step(5);

        // glitch shorter than the debounce window
        btn_start_raw = 1'b1; step(3); btn_start_raw = 1'b0; step(10);

        // count-up: run, pause, resume, clear
        press(0, 10, 12);
        press(0, 10, 12);
        press(0, 10, 12);
        press(1, 10, 12);

        // count-down with over-range preset, reach DONE and blink
        mode_sw = 2'b01; load_sw = 8'h9F; step(3);
        press(0, 10, 12);
        step(3);
        timer_zero = 1'b1; step(2); timer_zero = 1'b0;
        wait_state(2'd3, 4, "count-down done");
        pulse_ticks(6);
        press(0, 10, 12);

        // zero preset in count-down is ignored
        load_sw = 8'h00; step(3);
        press(0, 10, 12);

        // mode 1x behaves as count-up and ignores timer_zero
        mode_sw = 2'b10; step(2);
        press(0, 10, 12);
        timer_zero = 1'b1; step(3); timer_zero = 1'b0;

        // start and clear together while running
        btn_start_raw = 1'b1; btn_clear_raw = 1'b1; step(10);
        btn_start_raw = 1'b0; btn_clear_raw = 1'b0; step(12);

        // start press coincident with timer_zero in count-down
        mode_sw = 2'b01; load_sw = 8'h25; step(3);
        press(0, 10, 12);
        btn_start_raw = 1'b1; step(7);
        timer_zero = 1'b1; step(1); timer_zero = 1'b0;
        step(2); btn_start_raw = 1'b0; step(12);
        wait_state(2'd3, 4, "coincident done");

        // reset while blanking in DONE
        pulse_ticks(2);
        reset = 1'b1; step(1);
        check_reset_outputs("mid-operation");
        reset = 1'b0; step(5);

        // button held across reset must not fire until pressed again
        btn_start_raw = 1'b1; reset = 1'b1; step(2);
        reset = 1'b0; step(15);
        btn_start_raw = 1'b0; step(12);
        mode_sw = 2'b00; step(2);
        press(0, 10, 12);
        press(1, 10, 12);

        // randomized traffic
        hold_s = 0; hold_c = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_s == 0) begin
                btn_start_raw = 1'($urandom_range(0, 1));
                hold_s = $urandom_range(1, 14);
            end
            if (hold_c == 0) begin
                btn_clear_raw = ($urandom_range(0, 3) == 0);
                hold_c = $urandom_range(1, 14);
            end
            hold_s = hold_s - 1;
            hold_c = hold_c - 1;
            if ($urandom_range(0, 49) == 0) mode_sw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)
                load_sw = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            timer_zero = ($urandom_range(0, 15) == 0);
            tick       = ($urandom_range(0, 3) == 0);
            reset      = ($urandom_range(0, 799) == 0);
            step(1);
        end
        reset = 1'b0; tick = 1'b0; timer_zero = 1'b0;
        btn_start_raw = 1'b0; btn_clear_raw = 1'b0;
        step(3);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles needed to accept a button level change.
REQ-002 The block SHALL have parameter BLINK_TICKS, default 50, meaning tick pulses per half-period of the DONE-state blink.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset; synchronous and active-high.
REQ-005 btn_start_raw  input  1  raw, asynchronous start/stop button.
REQ-006 btn_clear_raw  input  1  raw, asynchronous clear button.
REQ-007 mode_sw  input  2  00 = count up, 01 = count down; 1x SHALL be treated as 00.
REQ-008 load_sw  input  8  BCD preset seconds: [7:4] tens, [3:0] ones.
REQ-009 tick  input  1  one-cycle timebase pulse from the clock divider.
REQ-010 timer_zero  input  1  level from the timer datapath; high when the count equals 00.00.
REQ-011 run_en  output  1  timer counts on tick while high.
REQ-012 clear  output  1  one-cycle pulse that zeroes the timer datapath.
REQ-013 load_strobe  output  1  one-cycle pulse that loads load_value into the timer.
REQ-014 load_value  output  8  sanitized BCD preset.
REQ-015 mode_out  output  2  mode latched for the current run.
REQ-016 blank  output  1  display blanking request.
REQ-017 state  output  2  FSM state encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-018 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-019 Each button SHALL have a debounced level and a counter; the counter increments while the synchronized value differs from the debounced level and resets to 0 when they are equal.
REQ-020 The debounced level SHALL toggle when the counter reaches DEBOUNCE_CYCLES-1, and the counter SHALL then reset to 0.
REQ-021 A press pulse SHALL assert for exactly one cycle, on the cycle after the debounced level rises; a release SHALL produce no pulse.
REQ-022 load_value SHALL be registered each cycle from load_sw, with each nibble greater than 9 clamped to 9.
REQ-023 In IDLE, mode_out SHALL track mode_sw; in all other states it SHALL hold its value.
REQ-024 IDLE -> RUN on a start press when mode_out = 00; clear SHALL also pulse in that same cycle.
REQ-025 IDLE -> RUN on a start press when mode_out = 01 and load_value != 00; load_strobe SHALL pulse in that same cycle.
REQ-026 In mode 01 with load_value = 00, a start press SHALL be ignored and the FSM SHALL remain in IDLE.
REQ-027 RUN -> PAUSE on a start press.
REQ-028 PAUSE -> RUN on a start press, with no clear or load pulse.
REQ-029 RUN -> DONE when mode_out = 01 and timer_zero = 1.
REQ-030 In mode 00, timer_zero SHALL be ignored.
REQ-031 DONE -> IDLE on a start press.
REQ-032 A clear press in any state SHALL force IDLE and pulse clear for one cycle.
REQ-033 Priority SHALL be: reset > clear press > timer_zero > start press.
REQ-034 A clear press and a start press in the same cycle SHALL result in IDLE, with only clear pulsed.
REQ-035 run_en SHALL be high exactly while state = RUN; it SHALL drop on the cycle the FSM leaves RUN.
REQ-036 In DONE, a blink counter SHALL count tick pulses; blank SHALL toggle each BLINK_TICKS ticks, starting at 0 on entry to DONE.
REQ-037 blank SHALL be 0 in all states other than DONE.
REQ-038 All outputs SHALL be registered; the FSM state change and its associated pulses SHALL appear one cycle after the press pulse.

Reset
REQ-039 While reset is high: state = IDLE, run_en = 0, clear = 0, load_strobe = 0, blank = 0, mode_out = 00, load_value = 00; synchronizers, debounce counters, debounced levels and the blink counter SHALL all be 0.
REQ-040 Reset asserted mid-run SHALL take effect at the next clk edge, and no press pulse SHALL be generated from a button already held when reset releases until it is released and pressed again.

Verification (DEBOUNCE_CYCLES=4, BLINK_TICKS=2)
REQ-041 Glitch rejection: btn_start_raw high for 3 cycles then low -> no press pulse, state stays 0.
REQ-042 Count-up run: mode_sw=00, hold start for 10 cycles -> exactly one press pulse; then clear=1 for 1 cycle, state=1, run_en=1; second press -> state=2, run_en=0.
REQ-043 Count-down run: mode_sw=01, load_sw=8'h9F -> load_value=8'h99; start -> load_strobe=1 for 1 cycle; drive timer_zero=1 -> state=3, run_en=0; with ticks, blank pattern 0,0,1,1,0.
REQ-044 Zero preset: mode_sw=01, load_sw=8'h00, start press -> state stays 0, load_strobe stays 0.
REQ-045 Simultaneous events: in RUN, start and clear presses in the same cycle -> state=0 with clear pulsed; separately, a start press coincident with timer_zero in mode 01 -> state=3.
REQ-046 Reset mid-operation: in DONE with blank=1, assert reset for 1 cycle -> all outputs at their reset values on the next cycle.
